// File: rtl/luhn_stream_checker_pkg.sv
// Shared types and mod-10 helpers for the streaming Luhn checker.
package luhn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX = 4'd9;

  // Luhn doubling of a BCD digit, result stays in 0..9.
  function automatic digit_t luhn_dbl(input digit_t d);
    logic [4:0] t;
    t = {d, 1'b0};
    return (t > 5'd9) ? digit_t'(t - 5'd9) : t[3:0];
  endfunction

  // Both operands must already be 0..9.
  function automatic digit_t mod10_add(input digit_t a, input digit_t b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 5'd10) ? digit_t'(s - 5'd10) : s[3:0];
  endfunction

endpackage

// File: rtl/luhn_stream_checker_if.sv
// Digit stream and verdict bundle; check_digit exists only with LUHN_CHECKDIGIT_EN.
interface luhn_stream_checker_if #(parameter int MAX_DIGITS = 19);
  import luhn_pkg::*;

  localparam int CNT_W = $clog2(MAX_DIGITS + 2);

  logic             digit_valid;
  digit_t           digit;
  logic             digit_last;
  logic             digit_ready;
  logic             result_valid;
  logic             result_ready;
  logic             card_ok;
  logic             err_len;
  logic             err_digit;
  logic [CNT_W-1:0] digit_count;
`ifdef LUHN_CHECKDIGIT_EN
  digit_t           check_digit;
`endif

  modport master (
    output digit_valid, digit, digit_last, result_ready,
    input  digit_ready, result_valid, card_ok, err_len, err_digit, digit_count
`ifdef LUHN_CHECKDIGIT_EN
    , input check_digit
`endif
  );

  modport slave (
    input  digit_valid, digit, digit_last, result_ready,
    output digit_ready, result_valid, card_ok, err_len, err_digit, digit_count
`ifdef LUHN_CHECKDIGIT_EN
    , output check_digit
`endif
  );

endinterface

// File: rtl/luhn_stream_checker_dual_acc.sv
// Two parallel mod-10 Luhn sums, one per possible parity of the final length.
module luhn_dual_acc
  import luhn_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   en,
  input  digit_t d,
  output digit_t acc_a,
  output digit_t acc_b,
  output logic   par
);

  digit_t a_q, a_d, b_q, b_d;
  logic   par_q, par_d;

  // par_q is the 0-based index parity of the next digit, i.e. count mod 2.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    par_d = par_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      par_d = 1'b0;
    end else if (en) begin
      par_d = ~par_q;
      if (!par_q) begin
        a_d = mod10_add(a_q, luhn_dbl(d));
        b_d = mod10_add(b_q, d);
      end else begin
        a_d = mod10_add(a_q, d);
        b_d = mod10_add(b_q, luhn_dbl(d));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      par_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      par_q <= par_d;
    end
  end

  assign acc_a = a_q;
  assign acc_b = b_q;
  assign par   = par_q;

endmodule

// File: rtl/luhn_stream_checker.sv
// Variable-length serial Luhn validator with held, handshaken verdict.
// Optional check_digit output under macro LUHN_CHECKDIGIT_EN.
module luhn_stream_checker
  import luhn_pkg::*;
#(
  parameter int MAX_DIGITS = 19,
  parameter int MIN_DIGITS = 2
) (
  input logic                  clk,
  input logic                  rst,
  luhn_stream_checker_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_DIGITS + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_dig_q, err_dig_d;
  logic             acc_clr, acc_en;
  logic             xfer, bad, done;
  digit_t           d_in, acc_a, acc_b, sel_acc;
  logic             par;

  assign bad  = bus.digit > BCD_MAX;
  assign d_in = bad ? '0 : bus.digit;
  assign done = (state_q == DONE);
  assign xfer = bus.digit_valid && !done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_dig_d = err_dig_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer) begin
          acc_en    = 1'b1;
          cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
          err_dig_d = err_dig_q | bad;
          state_d   = bus.digit_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d   = IDLE;
          cnt_d     = '0;
          err_dig_d = 1'b0;
          acc_clr   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_dig_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_dig_q <= err_dig_d;
    end
  end

  luhn_dual_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .d     (d_in),
    .acc_a (acc_a),
    .acc_b (acc_b),
    .par   (par)
  );

  // par is N mod 2 once the last digit is in: even N checks acc_a.
  assign sel_acc = par ? acc_b : acc_a;

  assign bus.digit_ready  = !done;
  assign bus.result_valid = done;
  assign bus.digit_count  = cnt_q;
  assign bus.err_digit    = err_dig_q;
  assign bus.err_len      = done && ((cnt_q < CNT_W'(MIN_DIGITS)) || (cnt_q > CNT_W'(MAX_DIGITS)));
  assign bus.card_ok      = done && (sel_acc == '0) && !bus.err_len && !err_dig_q;

`ifdef LUHN_CHECKDIGIT_EN
  digit_t last_q, last_d;
  digit_t rest, neg_last;

  always_comb begin
    last_d = last_q;
    if (acc_clr)   last_d = '0;
    else if (acc_en) last_d = d_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= '0;
    else      last_q <= last_d;
  end

  // Sum of every digit except the last, then the digit that closes it to 0.
  assign neg_last        = (last_q == '0) ? '0 : digit_t'(4'd10 - last_q);
  assign rest            = mod10_add(sel_acc, neg_last);
  assign bus.check_digit = (err_dig_q || rest == '0) ? '0 : digit_t'(4'd10 - rest);
`endif

endmodule

// File: tb/tb_luhn_stream_checker.sv
// Directed plus random numbers checked against a right-to-left Luhn reference.
module tb_luhn_stream_checker;
  localparam int MAXD = 19;
  localparam int MIND = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   rv_rises = 0;
  logic rv_prev;

  always #5 clk = ~clk;

  luhn_stream_checker_if #(.MAX_DIGITS(MAXD)) bus();

  luhn_stream_checker #(.MAX_DIGITS(MAXD), .MIN_DIGITS(MIND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) rv_prev <= 1'b0;
    else begin
      rv_prev <= bus.result_valid;
      if (bus.result_valid && !rv_prev) rv_rises <= rv_rises + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: classic Luhn, doubling every second digit counted from the right.
  task automatic model(input int q[$], output bit ok, output bit el, output bit ed,
                       output int cnt, output int cd);
    int n, s, sl, v, r;
    n = q.size(); s = 0; sl = 0; ed = 0;
    for (int i = 0; i < n; i++) begin
      v = q[i];
      if (v > 9) begin ed = 1; v = 0; end
      r = n - 1 - i;
      if (r % 2 == 1) v = (2 * v > 9) ? 2 * v - 9 : 2 * v;
      s += v;
      if (i != n - 1) sl += v;
    end
    el  = (n < MIND) || (n > MAXD);
    ok  = (s % 10 == 0) && !el && !ed;
    cnt = (n > MAXD + 1) ? MAXD + 1 : n;
    cd  = ed ? 0 : (10 - sl % 10) % 10;
  endtask

  task automatic check_verdict(input string tag, input bit ok, input bit el, input bit ed,
                               input int cnt, input int cd);
    chk({tag, ".rv"},    32'(bus.result_valid), 32'd1);
    chk({tag, ".ok"},    32'(bus.card_ok), 32'(ok));
    chk({tag, ".elen"},  32'(bus.err_len), 32'(el));
    chk({tag, ".edig"},  32'(bus.err_digit), 32'(ed));
    chk({tag, ".cnt"},   32'(bus.digit_count), 32'(cnt));
    chk({tag, ".drdy"},  32'(bus.digit_ready), 32'd0);
`ifdef LUHN_CHECKDIGIT_EN
    chk({tag, ".cdig"},  32'(bus.check_digit), 32'(cd));
`else
    if (cd < 0) $display("unreachable");
`endif
  endtask

  task automatic run_num(input string tag, input int q[$], input bit gaps, input int hold);
    bit ok, el, ed;
    int cnt, cd, v;
    model(q, ok, el, ed, cnt, cd);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.digit_valid = 1'b0;
        bus.result_ready = 1'($urandom);
        @(posedge clk); #1;
      end
      if (i == 0) chk({tag, ".rdy0"}, 32'(bus.digit_ready), 32'd1);
      v = q[i];
      bus.digit_valid  = 1'b1;
      bus.digit        = 4'(v);
      bus.digit_last   = (i == q.size() - 1);
      bus.result_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.digit_valid = 1'b0; bus.digit_last = 1'b0; bus.result_ready = 1'b0;
    check_verdict(tag, ok, el, ed, cnt, cd);
    for (int h = 0; h < hold; h++) begin
      bus.digit_valid = 1'b1; bus.digit = 4'd3; bus.digit_last = 1'b1;
      @(posedge clk); #1;
      check_verdict({tag, ".hold"}, ok, el, ed, cnt, cd);
    end
    bus.digit_valid = 1'b0; bus.digit_last = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    chk({tag, ".acc.rv"},   32'(bus.result_valid), 32'd0);
    chk({tag, ".acc.drdy"}, 32'(bus.digit_ready), 32'd1);
    chk({tag, ".acc.cnt"},  32'(bus.digit_count), 32'd0);
    chk({tag, ".acc.edig"}, 32'(bus.err_digit), 32'd0);
  endtask

  initial begin
    int q[$];
    int n, snap;
    bus.digit_valid = 1'b0; bus.digit = '0; bus.digit_last = 1'b0; bus.result_ready = 1'b0;
    #12;
    chk("rst.rv",   32'(bus.result_valid), 32'd0);
    chk("rst.drdy", 32'(bus.digit_ready), 32'd1);
    chk("rst.ok",   32'(bus.card_ok), 32'd0);
    chk("rst.elen", 32'(bus.err_len), 32'd0);
    chk("rst.edig", 32'(bus.err_digit), 32'd0);
    chk("rst.cnt",  32'(bus.digit_count), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    q = {4,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
    run_num("visa16", q, 0, 0);
    q = {7,9,9,2,7,3,9,8,7,1,3};
    run_num("odd11ok", q, 0, 0);
    q = {7,9,9,2,7,3,9,8,7,1,4};
    run_num("odd11bad", q, 0, 0);
    q = {4,1,1,1,1,1,1,1,1,1,1,1,1,1,1,2};
    run_num("hold5", q, 0, 5);
    q = {};
    for (int i = 0; i < 20; i++) q.push_back($urandom_range(0, 9));
    run_num("len20", q, 0, 0);
    q = {5};
    run_num("len1", q, 0, 0);
    q = {4,1,1,1,1,1,10,1,1,1,1,1,1,1,1,1};
    run_num("baddig", q, 0, 0);
    q = {3,4};
    run_num("len2", q, 0, 0);

    // Reset mid-number drops the partial number.
    snap = rv_rises;
    for (int i = 0; i < 8; i++) begin
      bus.digit_valid = 1'b1; bus.digit = 4'd4; bus.digit_last = 1'b0;
      @(posedge clk); #1;
    end
    bus.digit_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("midrst.cnt",  32'(bus.digit_count), 32'd0);
    chk("midrst.drdy", 32'(bus.digit_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q = {4,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
    run_num("postrst", q, 0, 0);
    chk("postrst.rises", 32'(rv_rises - snap), 32'd1);

    for (int t = 0; t < 30; t++) begin
      q = {};
      n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
      run_num($sformatf("rnd%0d", t), q, 1, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
